// File: rtl/sc_ienc.sv
// Sequential MIPS instruction encoder / program loader.
// Turns symbolic instructions into machine words and streams them into instruction memory.
module sc_ienc #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_id,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_sa,
    input  logic [15:0] in_imm,
    input  logic [31:0] in_target,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic [15:0] count,
    output logic        full,
    output logic        err,
    output logic [1:0]  err_code
);

    // state | meaning
    // IDLE  | waiting for an instruction (in_ready unless full/start)
    // WRITE | one-cycle memory write of the latched word at pc
    // ERR   | illegal instruction seen; parked until start
    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_ERR
    } state_t;

    localparam logic [15:0] DEPTH_CNT = 16'(DEPTH_WORDS);

    state_t      state;
    logic [31:0] pc;

    logic [31:0] enc_word;
    logic        enc_bad;
    logic [1:0]  enc_code;
    logic [29:0] pc4_w;
    logic [29:0] diff_w;
    logic        tgt_misal;
    logic        br_oor;
    logic        region_mis;

    assign in_ready = (state == S_IDLE) & ~full & ~start;

    // Word-granular arithmetic: pc is always word aligned and a misaligned
    // target is rejected before the offset is used, so the low bits carry nothing.
    always_comb begin
        pc4_w      = pc[31:2] + 30'd1;
        diff_w     = in_target[31:2] - pc4_w;
        tgt_misal  = |in_target[1:0];
        br_oor     = ~((&diff_w[29:15]) | ~(|diff_w[29:15]));
        region_mis = in_target[31:28] != pc4_w[29:26];
        enc_word   = 32'd0;
        enc_bad    = 1'b0;
        enc_code   = 2'd0;
        case (in_id)
            5'd0:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100000};
            5'd1:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100010};
            5'd2:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100100};
            5'd3:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100101};
            5'd4:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100110};
            5'd5:  enc_word = {6'b000000, 5'd0, in_rt, in_rd, in_sa, 6'b000000};
            5'd6:  enc_word = {6'b000000, 5'd0, in_rt, in_rd, in_sa, 6'b000010};
            5'd7:  enc_word = {6'b000000, 5'd0, in_rt, in_rd, in_sa, 6'b000011};
            5'd8:  enc_word = {6'b000000, in_rs, 15'd0, 6'b001000};
            5'd9:  enc_word = {6'b001000, in_rs, in_rt, in_imm};
            5'd10: enc_word = {6'b001100, in_rs, in_rt, in_imm};
            5'd11: enc_word = {6'b001101, in_rs, in_rt, in_imm};
            5'd12: enc_word = {6'b001110, in_rs, in_rt, in_imm};
            5'd13: enc_word = {6'b100011, in_rs, in_rt, in_imm};
            5'd14: enc_word = {6'b101011, in_rs, in_rt, in_imm};
            5'd15, 5'd16: begin
                enc_word = {5'b00010, in_id == 5'd16, in_rs, in_rt, diff_w[15:0]};
                if (tgt_misal) begin
                    enc_bad  = 1'b1;
                    enc_code = 2'd1;
                end else if (br_oor) begin
                    enc_bad  = 1'b1;
                    enc_code = 2'd2;
                end
            end
            5'd17: enc_word = {6'b001111, 5'd0, in_rt, in_imm};
            5'd18, 5'd19: begin
                enc_word = {5'b00001, in_id == 5'd19, in_target[27:2]};
                if (tgt_misal) begin
                    enc_bad  = 1'b1;
                    enc_code = 2'd1;
                end else if (region_mis) begin
                    enc_bad  = 1'b1;
                    enc_code = 2'd3;
                end
            end
            default: begin
                enc_bad  = 1'b1;
                enc_code = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            pc         <= BASE_ADDR;
            count      <= 16'd0;
            full       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            // A write already on the bus completes; only the pointer rewinds.
            if (start) begin
                state    <= S_IDLE;
                pc       <= BASE_ADDR;
                count    <= 16'd0;
                full     <= 1'b0;
                err      <= 1'b0;
                err_code <= 2'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (in_valid && in_ready) begin
                            if (enc_bad) begin
                                state    <= S_ERR;
                                err      <= 1'b1;
                                err_code <= enc_code;
                            end else begin
                                state      <= S_WRITE;
                                imem_we    <= 1'b1;
                                imem_addr  <= pc;
                                imem_wdata <= enc_word;
                            end
                        end
                    end
                    S_WRITE: begin
                        state <= S_IDLE;
                        pc    <= pc + 32'd4;
                        count <= count + 16'd1;
                        full  <= (count + 16'd1) == DEPTH_CNT;
                    end
                    default: state <= S_ERR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sc_ienc.sv
// Scoreboard bench for sc_ienc: expected memory writes are queued by the stimulus,
// a negedge monitor pops and compares every write the DUT issues.
module tb_sc_ienc;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_id = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_sa = '0;
    logic [15:0] in_imm = '0;
    logic [31:0] in_target = '0;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata;
    logic [15:0] count;
    logic        full, err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t sb[$];

    sc_ienc #(.DEPTH_WORDS(4), .BASE_ADDR(32'h0)) dut (
        .clock(clock), .resetn(resetn), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_id(in_id), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa),
        .in_imm(in_imm), .in_target(in_target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .err(err), .err_code(err_code)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("write_addr", imem_addr, e.a);
                chk("write_data", imem_wdata, e.d);
            end
        end
    end

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        sb.push_back(e);
    endtask

    // Called just after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [4:0] id, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sa,
                        input logic [15:0] imm, input logic [31:0] tgt);
        int n;
        in_id = id; in_rs = rs; in_rt = rt; in_rd = rd; in_sa = sa;
        in_imm = imm; in_target = tgt;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clock);
            if (in_ready === 1'b1) break;
            n++;
            if (n > 20) break;
        end
        if (n > 20) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: in_ready %b expected 1", in_ready);
        end
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic err_case(input string name, input logic [4:0] id, input logic [31:0] tgt,
                            input logic [1:0] code);
        send(id, 5'd1, 5'd2, 5'd0, 5'd0, 16'd0, tgt);
        @(negedge clock);
        chk({name, "_err"}, 32'(err), 32'd1);
        chk({name, "_code"}, 32'(err_code), 32'(code));
        chk({name, "_ready"}, 32'(in_ready), 32'd0);
        @(posedge clock);
        #1 pulse_start();
        @(negedge clock);
        chk({name, "_cleared"}, 32'(err), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        cycles(2);
        @(negedge clock);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_wdata", imem_wdata, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        @(posedge clock);
        #1 resetn = 1'b1;
        cycles(1);

        start = 1'b1;
        @(negedge clock);
        chk("ready_during_start", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1 start = 1'b0;

        expect_wr(32'h0, 32'h0022_1820);
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 32'd0);
        @(negedge clock);
        @(negedge clock);
        chk("count_after_add", 32'(count), 32'd1);
        @(posedge clock);
        #1;

        expect_wr(32'h4, 32'h8CA4_0008);
        send(5'd13, 5'd5, 5'd4, 5'd0, 5'd0, 16'd8, 32'd0);
        @(negedge clock);
        chk("ready_low_in_write", 32'(in_ready), 32'd0);
        @(negedge clock);
        chk("ready_back_t2", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;

        expect_wr(32'h8, 32'h0003_1100);
        send(5'd5, 5'd7, 5'd3, 5'd2, 5'd4, 16'd0, 32'd0);

        expect_wr(32'hC, 32'h1022_FFFC);
        send(5'd15, 5'd1, 5'd2, 5'd0, 5'd0, 16'd0, 32'h0);
        @(negedge clock);
        @(negedge clock);
        chk("full_set", 32'(full), 32'd1);
        chk("count_at_full", 32'(count), 32'd4);
        @(posedge clock);
        #1;

        in_id = 5'd0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("ready_when_full", 32'(in_ready), 32'd0);
        end
        @(posedge clock);
        #1 in_valid = 1'b0;
        chk("no_err_when_full", 32'(err), 32'd0);

        pulse_start();
        @(negedge clock);
        chk("full_cleared", 32'(full), 32'd0);
        chk("count_cleared", 32'(count), 32'd0);
        @(posedge clock);
        #1;
        expect_wr(32'h0, 32'h0C00_0010);
        send(5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 32'h40);
        cycles(1);

        pulse_start();
        err_case("bad_id", 5'd25, 32'h0, 2'd0);
        err_case("bad_id_prio", 5'd20, 32'h3, 2'd0);
        err_case("misaligned", 5'd15, 32'h21, 2'd1);
        err_case("br_range", 5'd15, 32'h0002_0004, 2'd2);
        err_case("j_region", 5'd18, 32'h1000_0000, 2'd3);

        expect_wr(32'h0, 32'h0022_1820);
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 32'd0);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        chk("count_after_midwrite_start", 32'(count), 32'd0);
        @(posedge clock);
        #1;
        expect_wr(32'h0, 32'h0085_3025);
        send(5'd3, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 32'd0);
        @(negedge clock);
        @(negedge clock);
        chk("count_restarted", 32'(count), 32'd1);
        @(posedge clock);
        #1;

        send(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 32'd0);
        chk("we_before_reset", 32'(imem_we), 32'd1);
        resetn = 1'b0;
        #1;
        chk("async_we", 32'(imem_we), 32'd0);
        chk("async_addr", imem_addr, 32'h0);
        chk("async_wdata", imem_wdata, 32'h0);
        chk("async_count", 32'(count), 32'd0);
        cycles(1);
        resetn = 1'b1;
        cycles(3);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
